// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: readback monitor for the multiplexed 4-digit seven-segment bus.
// Synchronizes and debounces the anode/segment bus, turns each stable active-low glyph
// back into a hex digit, assembles complete 4-digit frames into a binary value, and
// flags blanked periods such as the low-time countdown flash.
module sseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned BLANK_TIMEOUT = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  output logic [15:0] digits,
  output logic [3:0]  digit_ok,
  output logic [13:0] value,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        blank
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES);
  localparam int unsigned BW = $clog2(BLANK_TIMEOUT + 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_TIMEOUT);
  localparam logic [BW-1:0] BLANK_PRE = BW'(BLANK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_BLANK
  } state_t;

  logic [10:0]   r_sync1;
  logic [10:0]   r_sync2;
  logic [SW-1:0] r_stab_cnt;
  logic          r_fired;
  logic [BW-1:0] r_blank_cnt;
  state_t        r_state;
  logic [3:0]    r_seen;
  logic [15:0]   r_digits;
  logic [3:0]    r_ok;
  logic [13:0]   r_value;
  logic          r_fv;
  logic          r_fe;
  logic          r_blank;

  logic [3:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_chg;
  logic          w_strobe;
  logic          w_idle;
  logic          w_onehot;
  logic [1:0]    w_pos;
  logic [3:0]    w_bit;
  logic          w_cap;
  logic [4:0]    w_glyph;
  logic          w_all_dec;

  state_t        w_state_nxt;
  logic [3:0]    w_seen_nxt;
  logic [15:0]   w_digits_nxt;
  logic [3:0]    w_ok_nxt;
  logic [13:0]   w_value_nxt;
  logic          w_fv_nxt;
  logic          w_fe_nxt;
  logic          w_blank_nxt;
  logic [BW-1:0] w_blank_cnt_nxt;

  // Inverse of the active-low 0-F glyph table: {legal, digit}.
  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    case (s)
      7'h40:   glyph_decode = {1'b1, 4'h0};
      7'h79:   glyph_decode = {1'b1, 4'h1};
      7'h24:   glyph_decode = {1'b1, 4'h2};
      7'h30:   glyph_decode = {1'b1, 4'h3};
      7'h19:   glyph_decode = {1'b1, 4'h4};
      7'h12:   glyph_decode = {1'b1, 4'h5};
      7'h02:   glyph_decode = {1'b1, 4'h6};
      7'h78:   glyph_decode = {1'b1, 4'h7};
      7'h00:   glyph_decode = {1'b1, 4'h8};
      7'h10:   glyph_decode = {1'b1, 4'h9};
      7'h08:   glyph_decode = {1'b1, 4'hA};
      7'h03:   glyph_decode = {1'b1, 4'hB};
      7'h46:   glyph_decode = {1'b1, 4'hC};
      7'h21:   glyph_decode = {1'b1, 4'hD};
      7'h06:   glyph_decode = {1'b1, 4'hE};
      7'h0E:   glyph_decode = {1'b1, 4'hF};
      default: glyph_decode = 5'b0_0000;
    endcase
  endfunction

  // x*10 as (x<<3)+(x<<1).
  function automatic logic [13:0] mul10(input logic [13:0] x);
    mul10 = (x << 3) + (x << 1);
  endfunction

  assign w_an      = r_sync2[10:7];
  assign w_seg     = r_sync2[6:0];
  assign w_chg     = (r_sync1 != r_sync2);
  assign w_strobe  = (r_stab_cnt == STAB_MAX) && !r_fired;
  assign w_idle    = (w_an == 4'hF);
  assign w_bit     = 4'b0001 << w_pos;
  assign w_cap     = w_strobe && w_onehot;
  assign w_glyph   = glyph_decode(w_seg);
  assign w_all_dec = (w_digits_nxt[3:0] <= 4'd9) && (w_digits_nxt[7:4] <= 4'd9) &&
                     (w_digits_nxt[11:8] <= 4'd9) && (w_digits_nxt[15:12] <= 4'd9);

  assign digits      = r_digits;
  assign digit_ok    = r_ok;
  assign value       = r_value;
  assign frame_valid = r_fv;
  assign frame_err   = r_fe;
  assign blank       = r_blank;

  // Two-flop synchronizer for the whole 11-bit bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {an, sseg};
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter; the change test looks at the value about to enter r_sync2 so the
  // count restarts on the same edge the new pattern lands. r_fired limits the strobe to
  // one cycle per stable pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stab_cnt <= '0;
      r_fired    <= 1'b0;
    end else if (w_chg) begin
      r_stab_cnt <= '0;
      r_fired    <= 1'b0;
    end else begin
      if (r_stab_cnt != STAB_MAX) r_stab_cnt <= r_stab_cnt + 1'b1;
      if (w_strobe) r_fired <= 1'b1;
    end
  end

  // Anode decode: exactly one low bit selects a position.
  always_comb begin
    w_onehot = 1'b0;
    w_pos    = 2'd0;
    case (w_an)
      4'b1110: begin w_onehot = 1'b1; w_pos = 2'd0; end
      4'b1101: begin w_onehot = 1'b1; w_pos = 2'd1; end
      4'b1011: begin w_onehot = 1'b1; w_pos = 2'd2; end
      4'b0111: begin w_onehot = 1'b1; w_pos = 2'd3; end
      default: ;
    endcase
  end

  // Next-state: blank timing, digit capture, frame assembly and completion.
  always_comb begin
    w_state_nxt     = r_state;
    w_seen_nxt      = r_seen;
    w_digits_nxt    = r_digits;
    w_ok_nxt        = r_ok;
    w_value_nxt     = r_value;
    w_fv_nxt        = 1'b0;
    w_fe_nxt        = 1'b0;
    w_blank_nxt     = r_blank;
    w_blank_cnt_nxt = '0;

    if (w_idle) begin
      w_blank_cnt_nxt = (r_blank_cnt != BLANK_MAX) ? r_blank_cnt + 1'b1 : r_blank_cnt;
      if (r_blank_cnt == BLANK_PRE) begin
        w_blank_nxt = 1'b1;
        w_state_nxt = S_BLANK;
        w_seen_nxt  = '0;
      end
    end

    if (w_cap) begin
      w_blank_nxt = 1'b0;
      if (w_glyph[4]) begin
        w_digits_nxt[{w_pos, 2'b00} +: 4] = w_glyph[3:0];
        w_ok_nxt[w_pos] = 1'b1;
      end else begin
        w_ok_nxt[w_pos] = 1'b0;
      end
      w_state_nxt = S_COLLECT;
      if ((r_state != S_COLLECT) || ((r_seen & w_bit) != 4'b0000)) begin
        w_seen_nxt = w_bit;
      end else if ((r_seen | w_bit) == 4'hF) begin
        w_seen_nxt = '0;
        if ((&w_ok_nxt) && w_all_dec) begin
          w_value_nxt = mul10(mul10(mul10({10'd0, w_digits_nxt[15:12]}) +
                                    {10'd0, w_digits_nxt[11:8]}) +
                              {10'd0, w_digits_nxt[7:4]}) + {10'd0, w_digits_nxt[3:0]};
          w_fv_nxt = 1'b1;
        end else begin
          w_fe_nxt = 1'b1;
        end
      end else begin
        w_seen_nxt = r_seen | w_bit;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_seen      <= '0;
      r_digits    <= '0;
      r_ok        <= '0;
      r_value     <= '0;
      r_fv        <= 1'b0;
      r_fe        <= 1'b0;
      r_blank     <= 1'b0;
      r_blank_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_seen      <= w_seen_nxt;
      r_digits    <= w_digits_nxt;
      r_ok        <= w_ok_nxt;
      r_value     <= w_value_nxt;
      r_fv        <= w_fv_nxt;
      r_fe        <= w_fe_nxt;
      r_blank     <= w_blank_nxt;
      r_blank_cnt <= w_blank_cnt_nxt;
    end
  end

endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Receive-side counterpart of the multiplexed seven-segment display driver. It samples the time-multiplexed anode/segment bus (`an`, `sseg`) that drives the 4-digit display, filters switching transients, and decodes each active-low segment pattern back into a 4-bit digit. It assembles complete 4-digit frames into a 14-bit binary value and detects blanked periods, such as the low-time countdown flash. It sits on the board-level display bus as a readback/self-check monitor for the parking-meter datapath.

## Interface
- `STABLE_CYCLES`, 16: consecutive identical synchronized samples required before a capture (min 2).
- `BLANK_TIMEOUT`, 8192: consecutive all-anodes-off cycles before `blank` asserts.
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `an` in 4: anode enables, active-low, one-hot-low when a digit is driven.
- `sseg` in 7: segments {g,f,e,d,c,b,a}, active-low.
- `digits` out 16: {d3,d2,d1,d0}, last decoded value per position.
- `digit_ok` out 4: per-position flag, 1 = last pattern captured was a legal glyph.
- `value` out 14: d3*1000+d2*100+d1*10+d0 of the last good frame.
- `frame_valid` out 1: one-cycle pulse when `value` updates.
- `frame_err` out 1: one-cycle pulse when a frame completes with an illegal or non-decimal digit.
- `blank` out 1: display currently blanked.

## Operation
- Reset values: `digits`=0, `digit_ok`=0, `value`=0, `frame_valid`=0, `frame_err`=0, `blank`=0, FSM=IDLE, seen mask=0, all counters 0.
- Sync: `an` and `sseg` pass through 2-flop synchronizers (11 bits). All downstream logic uses the synchronized copies.
- Stability filter: `stab_cnt` clears when the synchronized {an,sseg} differs from the previous cycle, else increments and saturates at `STABLE_CYCLES`-1. A capture strobe fires in the single cycle the counter reaches `STABLE_CYCLES`-1; it does not repeat until the bus changes.
- Anode decode: exactly one zero bit gives position i and capture is allowed. If all bits are 1, no capture and the blank counter runs. Two or more zero bits: no capture, the strobe is ignored.
- Glyph decode: inverse of the standard active-low 0–F table (0=1000000, 1=1111001, … 9=0010000, A=0001000 … F=0001110). On a legal glyph, the digit is written and `digit_ok[i]`=1. On any other pattern, the digit is held, `digit_ok[i]`=0, and the position still counts as seen.
- FSM states: IDLE, COLLECT, BLANK.
  - IDLE/BLANK → COLLECT on any capture; seen = {bit i}.
  - COLLECT: capture of an unseen i sets seen[i]. Capture of an already-seen i restarts with seen = {bit i}, which covers missed slots.
  - When seen becomes 1111: if all four `digit_ok` (including the one being written) and all digits ≤ 9, `value` is loaded and `frame_valid` pulses; otherwise `value` is held and `frame_err` pulses. In both cases seen is cleared and the FSM stays in COLLECT.
- Blank: `blank_cnt` increments while synchronized `an`=1111 and clears otherwise. At `BLANK_TIMEOUT`, `blank`=1, FSM=BLANK, seen=0. `blank` clears on the edge of the next capture. `blank_cnt` saturates.
- Arithmetic: `value` is computed from the incoming digit set with shifts and adds; max 9999 fits 14 bits, so no saturation is needed.

## Timing
- A bus change stable from edge 0 appears synchronized after edge 2. The capture strobe is asserted after `STABLE_CYCLES`-1 further edges, and the digit register updates on the next edge: latency = 2+`STABLE_CYCLES` cycles.
- `frame_valid`, `frame_err` and `value` update on the same edge as the completing digit write. Pulses last exactly one cycle.
- `rst_n` low at any time clears everything immediately. A partial frame is discarded, and a full fresh set of four positions is required after release.
- Capture and blank-count never coincide, because a capture requires a zero anode bit.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `BLANK_TIMEOUT`=64.
- Reset: pulse `rst_n` low asynchronously mid-cycle -> all outputs 0 immediately, `blank`=0.
- Scan "1234": drive an=1110/sseg=0011001, an=1101/0110000, an=1011/0100100, an=0111/1111001, 20 cycles each -> exactly one `frame_valid` pulse, `value`=1234, `digit_ok`=1111, `digits`=0x1234.
- Glitch: insert a 3-cycle slot with an=1110/sseg=1000000 between valid slots -> no capture, `digits[3:0]` unchanged, no extra pulses.
- Hex glyph: scan with digit 1 = 0001000 (A) -> `frame_err` pulse, `value` keeps 1234, `digits[7:4]`=0xA.
- Blank/flash: hold an=1111 for 70 cycles -> `blank`=1 at cycle 64+2, FSM=BLANK. The next stable digit clears `blank`, and a full frame is needed before `frame_valid`.
- Reset mid-frame: after digits 0 and 1 are captured, pulse `rst_n` -> seen cleared. The next frame needs all four positions, and `value` is 0 until it completes.
